addr_rule_table: RTL



---
 rtl/addr_rule_table.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/addr_rule_table.sv
// Programmable address-range rule table: a config register file holding
// START/END/CTRL rules and a one-stage registered lookup that resolves an address to a port index.
module addr_rule_table #(
  parameter int NUM_RULES   = 16,
  parameter int NUM_PORTS   = 6,
  parameter int AW          = 32,
  parameter int DEFAULT_IDX = 2,
  localparam int IW = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cfg_req_i,
  input  logic          cfg_we_i,
  input  logic [11:0]   cfg_addr_i,
  input  logic [31:0]   cfg_wdata_i,
  output logic          cfg_rsp_valid_o,
  output logic [31:0]   cfg_rdata_o,
  output logic          cfg_err_o,
  input  logic          lk_valid_i,
  output logic          lk_ready_o,
  input  logic [AW-1:0] lk_addr_i,
  output logic          res_valid_o,
  input  logic          res_ready_i,
  output logic [IW-1:0] res_idx_o,
  output logic          res_hit_o
);

  localparam logic [6:0] NR = 7'(NUM_RULES);
  localparam logic [8:0] NP = 9'(NUM_PORTS);

  logic [AW-1:0] start_r [NUM_RULES];
  logic [AW-1:0] end_r   [NUM_RULES];
  logic          en_r    [NUM_RULES];
  logic [7:0]    idx_r   [NUM_RULES];
  logic [7:0]    dflt_r;
  logic          lock_r;
  logic [31:0]   miss_cnt_r;

  logic          rsp_valid_r;
  logic [31:0]   rdata_r;
  logic          err_r;
  logic          res_valid_r;
  logic [IW-1:0] res_idx_r;
  logic          res_hit_r;

  logic [5:0]    sel_rule_s;
  logic [1:0]    reg_sel_s;
  logic          is_rule_s;
  logic          is_gctrl_s;
  logic          is_miss_s;
  logic          idx_bad_s;
  logic          err_s;
  logic          wr_ok_s;
  logic [31:0]   rdata_s;
  logic          hit_s;
  logic [IW-1:0] hit_idx_s;
  logic          lk_accept_s;

  // Config address decode, error classification and read mux
  always_comb begin
    sel_rule_s = cfg_addr_i[9:4];
    reg_sel_s  = cfg_addr_i[3:2];
    is_rule_s  = (cfg_addr_i[11:10] == 2'b00) && (reg_sel_s != 2'b11) &&
                 ({1'b0, sel_rule_s} < NR);
    is_gctrl_s = (cfg_addr_i == 12'h400);
    is_miss_s  = (cfg_addr_i == 12'h404);
    idx_bad_s  = ({1'b0, cfg_wdata_i[7:0]} >= NP);
    err_s      = 1'b0;
    if (cfg_addr_i[1:0] != 2'b00) begin
      err_s = 1'b1;
    end else if (is_rule_s) begin
      err_s = cfg_we_i && (lock_r || ((reg_sel_s == 2'b10) && idx_bad_s));
    end else if (is_gctrl_s) begin
      err_s = cfg_we_i && (lock_r || idx_bad_s);
    end else if (is_miss_s) begin
      err_s = 1'b0;
    end else begin
      err_s = 1'b1;
    end
    wr_ok_s = cfg_req_i && cfg_we_i && !err_s;
    rdata_s = 32'h0000_0000;
    if (!err_s && !cfg_we_i) begin
      if (is_gctrl_s) begin
        rdata_s = {lock_r, 23'd0, dflt_r};
      end else if (is_miss_s) begin
        rdata_s = miss_cnt_r;
      end else begin
        for (int n = 0; n < NUM_RULES; n++) begin
          if (sel_rule_s == 6'(n)) begin
            case (reg_sel_s)
              2'b00:   rdata_s = 32'(start_r[n]);
              2'b01:   rdata_s = 32'(end_r[n]);
              2'b10:   rdata_s = {en_r[n], 23'd0, idx_r[n]};
              default: rdata_s = 32'h0000_0000;
            endcase
          end else begin
            rdata_s = rdata_s;
          end
        end
      end
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  // Priority match: scanning downward leaves the lowest-numbered hit in place
  always_comb begin
    hit_s     = 1'b0;
    hit_idx_s = {IW{1'b0}};
    for (int n = NUM_RULES - 1; n >= 0; n--) begin
      if (en_r[n] && (lk_addr_i >= start_r[n]) && (lk_addr_i <= end_r[n])) begin
        hit_s     = 1'b1;
        hit_idx_s = idx_r[n][IW-1:0];
      end else begin
        hit_s     = hit_s;
      end
    end
  end

  assign lk_ready_o  = !res_valid_r || res_ready_i;
  assign lk_accept_s = lk_valid_i && lk_ready_o;

  // Rule table and global control registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int n = 0; n < NUM_RULES; n++) begin
        start_r[n] <= {AW{1'b0}};
        end_r[n]   <= {AW{1'b0}};
        en_r[n]    <= 1'b0;
        idx_r[n]   <= 8'd0;
      end
      dflt_r <= 8'(DEFAULT_IDX);
      lock_r <= 1'b0;
    end else if (wr_ok_s) begin
      if (is_gctrl_s) begin
        dflt_r <= cfg_wdata_i[7:0];
        lock_r <= lock_r | cfg_wdata_i[31];
      end
      for (int n = 0; n < NUM_RULES; n++) begin
        if (is_rule_s && (sel_rule_s == 6'(n))) begin
          case (reg_sel_s)
            2'b00: start_r[n] <= AW'(cfg_wdata_i);
            2'b01: end_r[n]   <= AW'(cfg_wdata_i);
            2'b10: begin
              en_r[n]  <= cfg_wdata_i[31];
              idx_r[n] <= cfg_wdata_i[7:0];
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Miss counter: a clear in the same cycle as a miss takes priority
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      miss_cnt_r <= 32'h0000_0000;
    end else if (wr_ok_s && is_miss_s) begin
      miss_cnt_r <= 32'h0000_0000;
    end else if (lk_accept_s && !hit_s && (miss_cnt_r != 32'hFFFF_FFFF)) begin
      miss_cnt_r <= miss_cnt_r + 32'd1;
    end
  end

  // Config response, one cycle after every request
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_r <= 1'b0;
      rdata_r     <= 32'h0000_0000;
      err_r       <= 1'b0;
    end else begin
      rsp_valid_r <= cfg_req_i;
      rdata_r     <= cfg_req_i ? rdata_s : 32'h0000_0000;
      err_r       <= cfg_req_i && err_s;
    end
  end

  // Lookup result stage; holds while downstream stalls
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_valid_r <= 1'b0;
      res_idx_r   <= {IW{1'b0}};
      res_hit_r   <= 1'b0;
    end else if (lk_accept_s) begin
      res_valid_r <= 1'b1;
      res_idx_r   <= hit_s ? hit_idx_s : dflt_r[IW-1:0];
      res_hit_r   <= hit_s;
    end else if (res_ready_i) begin
      res_valid_r <= 1'b0;
    end
  end

  assign cfg_rsp_valid_o = rsp_valid_r;
  assign cfg_rdata_o     = rdata_r;
  assign cfg_err_o       = err_r;
  assign res_valid_o     = res_valid_r;
  assign res_idx_o       = res_idx_r;
  assign res_hit_o       = res_hit_r;

endmodule
